// File: rtl/ray_dispatch_pkg.sv
// Shared definitions for the ray dispatch sequencer.
// - fip_t: signed Q16.16 fixed-point scalar.
// - FIP_ONE / FIP_MAX / FIP_MIN: 1.0 and the fixed-point extremes.
// - RAY_W and ray field offsets: layout of the flattened ray
//   {D.z, D.y, D.x, E.z, E.y, E.x}, with E.x in the low word.
// - state_e: sequencer FSM states.
package ray_dispatch_pkg;

  typedef logic signed [31:0] fip_t;

  localparam fip_t FIP_ONE = 32'sh0001_0000;
  localparam fip_t FIP_MAX = 32'sh7fff_ffff;
  localparam fip_t FIP_MIN = 32'sh8000_0000;

  localparam int unsigned RAY_W     = 192;
  localparam int unsigned RAY_EX_LSB = 0;
  localparam int unsigned RAY_EY_LSB = 32;
  localparam int unsigned RAY_EZ_LSB = 64;
  localparam int unsigned RAY_DX_LSB = 96;
  localparam int unsigned RAY_DY_LSB = 128;
  localparam int unsigned RAY_DZ_LSB = 160;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_ARM,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ray_dispatch.sv
// Upstream sequencer for the triangle intersector batch unit.
// Pulls one ray at a time from the ray stream, launches one intersector
// batch over the full triangle list, waits for batch completion and emits
// one {hit, t, tri_index, ray_id} result per ray on a valid/ready stream.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, i_ray_cnt, i_tri_cnt, i_baseaddr   frame start and parameters
//   ray_valid/ray_ready/ray_data              ray input stream
//   ins_ivalid, ins_baseaddr, ins_ray, ins_tri_cnt   batch launch (held)
//   ins_hit, ins_t, ins_tri_index, ins_finish        batch result
//   res_valid/res_ready, res_hit, res_t, res_tri_index, res_ray_id  results
//   busy, done                  frame status
module ray_dispatch #(
  parameter int unsigned RAY_W = 192,
  parameter int unsigned ID_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ID_W-1:0]  i_ray_cnt,
  input  logic [31:0]      i_tri_cnt,
  input  logic [31:0]      i_baseaddr,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic [RAY_W-1:0] ray_data,
  output logic             ins_ivalid,
  output logic [31:0]      ins_baseaddr,
  output logic [RAY_W-1:0] ins_ray,
  output logic [31:0]      ins_tri_cnt,
  input  logic             ins_hit,
  input  logic [31:0]      ins_t,
  input  logic [31:0]      ins_tri_index,
  input  logic             ins_finish,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [31:0]      res_t,
  output logic [31:0]      res_tri_index,
  output logic [ID_W-1:0]  res_ray_id,
  output logic             busy,
  output logic             done
);

  import ray_dispatch_pkg::*;

  state_e           state_q,     state_d;
  logic [ID_W-1:0]  ray_cnt_q,   ray_cnt_d;
  logic [ID_W-1:0]  ray_id_q,    ray_id_d;
  logic [31:0]      tri_cnt_q,   tri_cnt_d;
  logic [31:0]      base_q,      base_d;
  logic [RAY_W-1:0] ray_q,       ray_d;
  logic             res_hit_q,   res_hit_d;
  fip_t             res_t_q,     res_t_d;
  logic [31:0]      res_idx_q,   res_idx_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    ray_cnt_d   = ray_cnt_q;
    ray_id_d    = ray_id_q;
    tri_cnt_d   = tri_cnt_q;
    base_d      = base_q;
    ray_d       = ray_q;
    res_hit_d   = res_hit_q;
    res_t_d     = res_t_q;
    res_idx_d   = res_idx_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ray_cnt_d = i_ray_cnt;
          tri_cnt_d = i_tri_cnt;
          base_d    = i_baseaddr;
          ray_id_d  = '0;
          busy_d    = 1'b1;
          state_d   = (i_ray_cnt == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (ray_valid) begin
          ray_d = ray_data;
          if (tri_cnt_q == '0) begin
            // An empty scene must not launch: the intersector's count-1 would wrap.
            res_hit_d   = 1'b0;
            res_t_d     = FIP_MAX;
            res_idx_d   = '0;
            res_valid_d = 1'b1;
            state_d     = ST_EMIT;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: state_d = ST_ARM;
      // finish is still high from the previous idle period this cycle.
      ST_ARM:    state_d = ST_WAIT;
      ST_WAIT: begin
        if (ins_finish) begin
          res_hit_d   = ins_hit;
          res_t_d     = fip_t'(ins_t);
          res_idx_d   = ins_tri_index;
          res_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ray_id_d    = ray_id_q + ID_W'(1);
          state_d     = (ray_id_q == ray_cnt_q - ID_W'(1)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ray_cnt_q   <= '0;
      ray_id_q    <= '0;
      tri_cnt_q   <= '0;
      base_q      <= '0;
      ray_q       <= '0;
      res_hit_q   <= 1'b0;
      res_t_q     <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ray_cnt_q   <= ray_cnt_d;
      ray_id_q    <= ray_id_d;
      tri_cnt_q   <= tri_cnt_d;
      base_q      <= base_d;
      ray_q       <= ray_d;
      res_hit_q   <= res_hit_d;
      res_t_q     <= res_t_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign ray_ready     = (state_q == ST_FETCH);
  assign ins_ivalid    = (state_q == ST_LAUNCH);
  assign done          = (state_q == ST_DONE);
  assign ins_baseaddr  = base_q;
  assign ins_ray       = ray_q;
  assign ins_tri_cnt   = tri_cnt_q;
  assign res_valid     = res_valid_q;
  assign res_hit       = res_hit_q;
  assign res_t         = res_t_q;
  assign res_tri_index = res_idx_q;
  assign res_ray_id    = ray_id_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ray_dispatch.sv
module tb_ray_dispatch;

  localparam int RAY_W = 192;
  localparam int ID_W  = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [ID_W-1:0]  i_ray_cnt = '0;
  logic [31:0]      i_tri_cnt = '0;
  logic [31:0]      i_baseaddr = '0;
  logic             ray_valid = 1'b0;
  logic             ray_ready;
  logic [RAY_W-1:0] ray_data = '0;
  logic             ins_ivalid;
  logic [31:0]      ins_baseaddr;
  logic [RAY_W-1:0] ins_ray;
  logic [31:0]      ins_tri_cnt;
  logic             ins_hit = 1'b0;
  logic [31:0]      ins_t = '0;
  logic [31:0]      ins_tri_index = '0;
  logic             ins_finish = 1'b1;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             res_hit;
  logic [31:0]      res_t;
  logic [31:0]      res_tri_index;
  logic [ID_W-1:0]  res_ray_id;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  ray_dispatch #(.RAY_W(RAY_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .i_ray_cnt(i_ray_cnt), .i_tri_cnt(i_tri_cnt), .i_baseaddr(i_baseaddr),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_data(ray_data),
    .ins_ivalid(ins_ivalid), .ins_baseaddr(ins_baseaddr), .ins_ray(ins_ray),
    .ins_tri_cnt(ins_tri_cnt), .ins_hit(ins_hit), .ins_t(ins_t),
    .ins_tri_index(ins_tri_index), .ins_finish(ins_finish),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_t(res_t), .res_tri_index(res_tri_index), .res_ray_id(res_ray_id),
    .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Intersector model: finish stays high (stale) through the launch and arm
  // cycles while garbage sits on the result lines, drops, then rises after
  // m_lat further cycles with the programmed result.
  logic        m_hit = 1'b0;
  logic [31:0] m_t   = '0;
  logic [31:0] m_idx = '0;
  int          m_lat = 1;
  logic        m_run = 1'b0;
  int          m_k   = 0;
  int          launches = 0;
  int          accepted = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_run      <= 1'b0;
      m_k        <= 0;
      ins_finish <= 1'b1;
    end else if (ins_ivalid) begin
      m_run         <= 1'b1;
      m_k           <= 0;
      ins_hit       <= 1'b1;
      ins_t         <= 32'hdead_beef;
      ins_tri_index <= 32'd99;
    end else if (m_run) begin
      m_k <= m_k + 1;
      if (m_k == 0) ins_finish <= 1'b0;
      if (m_k == m_lat) begin
        ins_finish    <= 1'b1;
        ins_hit       <= m_hit;
        ins_t         <= m_t;
        ins_tri_index <= m_idx;
        m_run         <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (ins_ivalid) launches <= launches + 1;
      if (ray_valid && ray_ready) accepted <= accepted + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [ID_W-1:0] rc, input logic [31:0] tc, input logic [31:0] base);
    i_ray_cnt  = rc;
    i_tri_cnt  = tc;
    i_baseaddr = base;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic feed_ray(input logic [RAY_W-1:0] d);
    int n = 0;
    ray_data = d;
    while (!ray_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ray_ready_wait", ray_ready, 1);
    ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [RAY_W-1:0] r0, r1, r2;
  int a0, l0, seen;

  initial begin
    r0 = {32'h0000_8000, 32'hffff_0000, 32'h0001_0000,
          32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    r1 = {6{32'h1234_5678}};
    r2 = {32'h0, 32'h0, 32'hffff_0000, 32'h0, 32'h0005_0000, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ray_ready", ray_ready, 0);
    check("rst_ins_ivalid", ins_ivalid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ins_ray", ins_ray, 0);
    check("rst_res_t", res_t, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single ray, three triangles, stale finish at launch
    m_hit = 1'b1; m_t = 32'h0001_8000; m_idx = 32'd2; m_lat = 1;
    l0 = launches;
    do_start(1, 3, 32'h1000_0000);
    check("t1_busy", busy, 1);
    check("t1_ray_ready", ray_ready, 1);
    feed_ray(r0);
    check("t1_ivalid", ins_ivalid, 1);
    check("t1_ins_ray", ins_ray, r0);
    check("t1_ins_tri_cnt", ins_tri_cnt, 3);
    check("t1_ins_base", ins_baseaddr, 32'h1000_0000);
    @(negedge clk);
    check("t1_arm_ivalid", ins_ivalid, 0);
    check("t1_arm_stale_finish", ins_finish, 1);
    check("t1_arm_no_capture", res_valid, 0);
    @(negedge clk);
    check("t1_wait_finish_low", ins_finish, 0);
    check("t1_wait_no_res", res_valid, 0);
    @(negedge clk);
    check("t1_finish_rise", ins_finish, 1);
    check("t1_res_latency0", res_valid, 0);
    @(negedge clk);
    check("t1_res_valid", res_valid, 1);
    check("t1_res_hit", res_hit, 1);
    check("t1_res_t", res_t, 32'h0001_8000);
    check("t1_res_idx", res_tri_index, 2);
    check("t1_res_id", res_ray_id, 0);
    check("t1_ray_held", ins_ray, r0);
    accept_res();
    check("t1_done", done, 1);
    check("t1_res_dropped", res_valid, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_busy_clr", busy, 0);
    check("t1_launches", launches - l0, 1);

    // Four rays with backpressure on ray 1, start while busy ignored
    l0 = launches;
    do_start(4, 5, 32'h2000_0000);
    for (int i = 0; i < 4; i++) begin
      m_hit = i[0];
      m_t   = 32'h0002_0000 + i;
      m_idx = 32'd10 + i;
      m_lat = i + 1;
      feed_ray(r0 ^ RAY_W'(i));
      wait_res("t2_res_wait");
      if (i == 1) begin
        a0 = accepted;
        ray_valid = 1'b1;
        ray_data  = r1;
        for (int k = 0; k < 10; k++) begin
          if (k == 4) begin
            i_ray_cnt = 9; i_tri_cnt = 77; start = 1'b1;
          end else begin
            start = 1'b0;
          end
          @(negedge clk);
          check("t2_stall_valid", res_valid, 1);
          check("t2_stall_t", res_t, 32'h0002_0001);
          check("t2_stall_ready", ray_ready, 0);
        end
        start = 1'b0;
        ray_valid = 1'b0;
        check("t2_stall_no_accept", accepted - a0, 0);
        check("t2_stall_launches", launches - l0, 2);
        check("t2_start_ignored", ins_tri_cnt, 5);
      end
      check("t2_id", res_ray_id, i);
      check("t2_hit", res_hit, i[0]);
      check("t2_t", res_t, 32'h0002_0000 + i);
      check("t2_idx", res_tri_index, 10 + i);
      accept_res();
    end
    check("t2_done", done, 1);
    @(negedge clk);
    check("t2_busy_clr", busy, 0);
    check("t2_launches", launches - l0, 4);

    // Empty scene: no launch, miss results
    l0 = launches;
    do_start(2, 0, 32'h3000_0000);
    for (int i = 0; i < 2; i++) begin
      feed_ray(r1 ^ RAY_W'(i));
      check("t4_res_valid", res_valid, 1);
      check("t4_hit", res_hit, 0);
      check("t4_t", res_t, 32'h7fff_ffff);
      check("t4_idx", res_tri_index, 0);
      check("t4_id", res_ray_id, i);
      accept_res();
    end
    check("t4_done", done, 1);
    check("t4_no_launch", launches - l0, 0);
    @(negedge clk);

    // Zero-ray frame
    a0 = accepted;
    ray_valid = 1'b1;
    do_start(0, 4, 32'h0);
    check("t5_done", done, 1);
    check("t5_ray_ready", ray_ready, 0);
    @(negedge clk);
    check("t5_done_pulse", done, 0);
    check("t5_busy", busy, 0);
    ray_valid = 1'b0;
    check("t5_no_ray", accepted - a0, 0);

    // Reset while waiting on the batch, then a fresh frame
    m_lat = 20;
    do_start(1, 2, 32'h4000_0000);
    feed_ray(r2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_done", done, 0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || res_valid) seen++;
    end
    check("t6_no_done", seen, 0);
    m_hit = 1'b1; m_t = 32'hffff_0000; m_idx = 32'd7; m_lat = 2;
    do_start(1, 1, 32'h5000_0000);
    feed_ray(r2);
    wait_res("t6_res_wait");
    check("t6_t", res_t, 32'hffff_0000);
    check("t6_idx", res_tri_index, 7);
    check("t6_id", res_ray_id, 0);
    check("t6_tri_cnt", ins_tri_cnt, 1);
    accept_res();
    check("t6_done_after", done, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
